// File: rtl/mult16_share_arb.sv
// mult16_share_arb -- round-robin arbiter that shares one unsigned 16x16
// array multiplier among NREQ beamforming channel requesters.
//
// Each requester offers an operand pair under valid/ready. One requester is
// granted per cycle (round-robin from ptr). Its operands drive the shared
// mult16_array. The 32-bit product is registered together with the
// requester index.
//
// Optional feature: define MULT16_ARB_PIPE_EN to insert an operand register
// stage between the grant mux and the multiplier. This makes the latency 2
// and keeps full throughput.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   requester id width, 2**IDW >= NREQ
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester operand valid              [NREQ]
//   req_ready  per-requester accept, one-hot or zero    [NREQ]
//   req_a      multiplicands, requester i at [16i+15:16i]
//   req_b      multipliers, same packing
//   res_valid  result valid
//   res_ready  downstream accept
//   res_data   unsigned product a*b                     [32]
//   res_id     index of the issuing requester           [IDW]
//   busy       an accepted operation is not yet retired
//   op_count   retired product count, wraps             [16]

// Unsigned 16x16 array multiplier: sum of shifted partial products.
module mult16_array (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    p = '0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) p = p + ({16'h0000, a} << i);
    end
  end
endmodule

module mult16_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 busy,
  output logic [15:0]          op_count
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           any_valid;
  logic           adv;        // the grant stage may accept an operand
  logic           res_adv;    // the result register may load
  logic           xfer;       // operand transfer this cycle
  logic           src_valid;  // valid feeding the result register
  logic [15:0]    mux_a, mux_b;
  logic [15:0]    mult_a, mult_b;
  logic [IDW-1:0] mult_id;
  logic [31:0]    product;

  // Round-robin scan from ptr upward. The loop runs high to low so that the
  // requester closest to ptr is the last one written, and so it wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          grant     = IDW'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        mux_a = req_a[16*i +: 16];
        mux_b = req_b[16*i +: 16];
      end
    end
  end

  // Nothing is accepted while reset is held. Operands offered during reset
  // would be discarded anyway.
  assign xfer      = any_valid && adv && !rst;
  assign req_ready = xfer ? (NREQ'(1) << grant) : '0;
  assign res_adv   = !res_valid || res_ready;

`ifdef MULT16_ARB_PIPE_EN
  logic           stage_valid;
  logic [15:0]    stage_a, stage_b;
  logic [IDW-1:0] stage_id;

  // The operand stage can take new data when it is empty or is draining
  // into the result register in this cycle.
  assign adv = !stage_valid || res_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_a     <= '0;
      stage_b     <= '0;
      stage_id    <= '0;
    end else if (adv) begin
      stage_valid <= xfer;
      if (xfer) begin
        stage_a  <= mux_a;
        stage_b  <= mux_b;
        stage_id <= grant;
      end
    end
  end

  assign mult_a    = stage_a;
  assign mult_b    = stage_b;
  assign mult_id   = stage_id;
  assign src_valid = stage_valid;
  assign busy      = res_valid || stage_valid;
`else
  assign adv       = res_adv;
  assign mult_a    = mux_a;
  assign mult_b    = mux_b;
  assign mult_id   = grant;
  assign src_valid = xfer;
  assign busy      = res_valid;
`endif

  mult16_array u_mult (
    .a (mult_a),
    .b (mult_b),
    .p (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + IDW'(1);
    end
  end

  // If a retire and a load happen in the same edge, the new result
  // overwrites the old one and res_valid stays high, so there is no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the result datapath is reset as well because res_data/res_id have defined reset values.
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      op_count  <= '0;
    end else begin
      if (res_adv) begin
        res_valid <= src_valid;
        if (src_valid) begin
          res_data <= product;
          res_id   <= mult_id;
        end
      end
      if (res_valid && res_ready) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mult16_share_arb.sv
// Directed self-checking bench for mult16_share_arb in the default
// (single-stage, latency 1) build with NREQ=4 and IDW=2.
// Inputs change 1 ns after the rising edge. Outputs are sampled at least
// 1 ns after the edge.
module tb_mult16_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_id;
  logic        busy;
  logic [15:0] op_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mult16_share_arb #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  initial begin
    int g;
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  res_data,       32'd0);
    check("rst_res_id",    32'(res_id),    32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Single request on requester 0.
    set_op(0, 16'h1234, 16'h5678);
    req_valid = 4'b0001;
    #1 check("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    #1;
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data",  res_data,       32'h06260060);
    check("single_id",    32'(res_id),    32'd0);
    check("single_busy",  32'(busy),      32'd1);
    check("idle_ready",   32'(req_ready), 32'd0);
    step();
    check("single_retired", 32'(res_valid), 32'd0);
    check("single_count",   32'(op_count),  32'd1);
    check("idle_busy",      32'(busy),      32'd0);

    // Corner values. Requester 3 is used so that ptr wraps to 0.
    set_op(3, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b1000;
    #1 check("corner1_ready", 32'(req_ready), 32'h8);
    step();
    check("corner1_data", res_data,    32'hFFFE0001);
    check("corner1_id",   32'(res_id), 32'd3);
    set_op(0, 16'h0000, 16'hABCD);
    req_valid = 4'b1001;
    #1 check("ptr_wrap_ready", 32'(req_ready), 32'h1);
    step();
    check("corner2_data", res_data,    32'h0);
    check("corner2_id",   32'(res_id), 32'd0);
    set_op(3, 16'h8000, 16'h0002);
    req_valid = 4'b1000;
    #1 check("corner3_ready", 32'(req_ready), 32'h8);
    step();
    check("corner3_data", res_data,    32'h00010000);
    check("corner3_id",   32'(res_id), 32'd3);

    // Fairness: all four requesters are valid and ptr is now 0.
    for (int i = 0; i < 4; i++) set_op(i, 16'(16'h0011 * (i + 1)), 16'h0100);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      g = k % 4;
      #1 check("fair_ready", 32'(req_ready), 32'(1 << g));
      step();
      check("fair_valid", 32'(res_valid), 32'd1);
      check("fair_id",    32'(res_id),    32'(g));
      check("fair_data",  res_data,       32'(32'h1100 * (g + 1)));
    end

    // Backpressure: the result for requester 1 is held and 0 and 2 wait.
    res_ready = 1'b0;
    req_valid = 4'b0101;
    check("bp_count", 32'(op_count), 32'd9);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_data",  res_data,       32'h2200);
      check("bp_id",    32'(res_id),    32'd1);
      step();
    end
    res_ready = 1'b1;
    #1 check("bp_rel_ready2", 32'(req_ready), 32'h4);
    step();
    check("bp_rel_id2",   32'(res_id), 32'd2);
    check("bp_rel_data2", res_data,    32'h3300);
    #1 check("bp_rel_ready0", 32'(req_ready), 32'h1);
    step();
    check("bp_rel_id0",    32'(res_id),    32'd0);
    check("bp_rel_data0",  res_data,       32'h1100);
    check("bp_rel_valid0", 32'(res_valid), 32'd1);
    req_valid = 4'b0000;
    step();
    check("bp_drained", 32'(res_valid), 32'd0);
    check("bp_count12", 32'(op_count),  32'd12);

    // op_count wrap: 12 + 65523 = 0xFFFF, then one more retire wraps to 0.
    set_op(0, 16'h0003, 16'h0005);
    req_valid = 4'b0001;
    repeat (65523) step();
    req_valid = 4'b0000;
    step();
    check("count_ffff", 32'(op_count),  32'hFFFF);
    check("count_idle", 32'(res_valid), 32'd0);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    check("wrap_data", res_data, 32'h0000000F);
    step();
    check("count_wrap", 32'(op_count), 32'd0);

    // Reset mid-stream while a result is held.
    set_op(1, 16'h0007, 16'h0009);
    res_ready = 1'b0;
    req_valid = 4'b0110;
    step();
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    check("pre_rst_id",    32'(res_id),    32'd1);
    check("pre_rst_data",  res_data,       32'h3F);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_data",  res_data,       32'd0);
    check("mid_rst_id",    32'(res_id),    32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    #1 check("post_rst_ready", 32'(req_ready), 32'h2);
    step();
    check("post_rst_id",    32'(res_id),    32'd1);
    check("post_rst_valid", 32'(res_valid), 32'd1);
    req_valid = 4'b0000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
